// File: rtl/sprite_engine_if.sv
// rtl/sprite_engine_if.sv - beam, attribute-write, bitmap ROM and pixel signals of sprite_engine
// master drives beam/writes/ROM data; slave is the sprite engine.
interface sprite_engine_if #(
    parameter int NSPR   = 4,
    parameter int SPR_W  = 8,
    parameter int SPR_H  = 16,
    parameter int CODE_W = 4
);
    localparam int IDX_W  = (NSPR > 1) ? $clog2(NSPR) : 1;
    localparam int ADDR_W = CODE_W + $clog2(SPR_H);

    logic [10:0]       hpos;
    logic [10:0]       vpos;
    logic              display_on;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [10:0]       wr_x;
    logic [10:0]       wr_y;
    logic [CODE_W-1:0] wr_code;
    logic [2:0]        wr_color;
    logic              wr_hflip;
    logic              wr_ena;
    logic [ADDR_W-1:0] bmp_addr;
    logic [SPR_W-1:0]  bmp_data;
    logic              pix_on;
    logic [2:0]        pix_rgb;
    logic              collision;

    modport master (
        output hpos, vpos, display_on,
        output wr_en, wr_idx, wr_x, wr_y, wr_code, wr_color, wr_hflip, wr_ena,
        input  bmp_addr,
        output bmp_data,
        input  pix_on, pix_rgb, collision
    );

    modport slave (
        input  hpos, vpos, display_on,
        input  wr_en, wr_idx, wr_x, wr_y, wr_code, wr_color, wr_hflip, wr_ena,
        output bmp_addr,
        input  bmp_data,
        output pix_on, pix_rgb, collision
    );
endinterface

// File: rtl/sprite_engine.sv
// rtl/sprite_engine.sv - multi-sprite overlay with hblank bitmap fetch, fixed priority and collision flag
// Optional feature macro: SPRITE_HFLIP_EN (per-sprite horizontal flip).
module sprite_engine #(
    parameter int NSPR     = 4,
    parameter int SPR_W    = 8,
    parameter int SPR_H    = 16,
    parameter int CODE_W   = 4,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 520
) (
    input  logic           CLK,
    input  logic           RST,
    sprite_engine_if.slave bus
);
    localparam int IDX_W  = (NSPR > 1) ? $clog2(NSPR) : 1;
    localparam int ROW_W  = $clog2(SPR_H);
    localparam int COL_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ADDR_W = CODE_W + ROW_W;

    localparam logic [10:0]      HA       = 11'(H_ACTIVE);
    localparam logic [10:0]      VA       = 11'(V_ACTIVE);
    localparam logic [10:0]      VLAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0]      SPR_H_11 = 11'(SPR_H);
    localparam logic [10:0]      SPR_W_11 = 11'(SPR_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSPR - 1);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(SPR_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Shadow set takes CPU writes; active set is what the beam renders.
    logic [10:0]       sh_x_q     [NSPR];
    logic [10:0]       sh_y_q     [NSPR];
    logic [CODE_W-1:0] sh_code_q  [NSPR];
    logic [2:0]        sh_color_q [NSPR];
    logic [NSPR-1:0]   sh_en_q;
    logic [10:0]       ac_x_q     [NSPR];
    logic [10:0]       ac_y_q     [NSPR];
    logic [CODE_W-1:0] ac_code_q  [NSPR];
    logic [2:0]        ac_color_q [NSPR];
    logic [NSPR-1:0]   ac_en_q;
    logic [NSPR-1:0]   flip;

    logic [SPR_W-1:0]  linebuf_q  [NSPR];
    logic [NSPR-1:0]   lvalid_q;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              lb_we;
    logic [10:0]       next_line;
    logic [10:0]       row;
    logic              row_hit;

    logic [10:0]       col     [NSPR];
    logic [COL_W-1:0]  bit_idx [NSPR];
    logic [NSPR-1:0]   opaque;
    logic              any_opaque;
    logic              multi_opaque;
    logic [2:0]        rgb_sel;

    logic              pix_on_q;
    logic [2:0]        pix_rgb_q;
    logic              collision_q;
    logic              swap;

    assign swap = (bus.hpos == 11'd0) && (bus.vpos == VA);

    // Swap copies the pre-write shadow value, so a coincident write waits a frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NSPR; i++) begin
                sh_x_q[i]     <= '0;
                sh_y_q[i]     <= '0;
                sh_code_q[i]  <= '0;
                sh_color_q[i] <= '0;
                ac_x_q[i]     <= '0;
                ac_y_q[i]     <= '0;
                ac_code_q[i]  <= '0;
                ac_color_q[i] <= '0;
            end
            sh_en_q <= '0;
            ac_en_q <= '0;
        end else begin
            if (swap) begin
                for (int i = 0; i < NSPR; i++) begin
                    ac_x_q[i]     <= sh_x_q[i];
                    ac_y_q[i]     <= sh_y_q[i];
                    ac_code_q[i]  <= sh_code_q[i];
                    ac_color_q[i] <= sh_color_q[i];
                end
                ac_en_q <= sh_en_q;
            end
            if (bus.wr_en) begin
                sh_x_q[bus.wr_idx]     <= bus.wr_x;
                sh_y_q[bus.wr_idx]     <= bus.wr_y;
                sh_code_q[bus.wr_idx]  <= bus.wr_code;
                sh_color_q[bus.wr_idx] <= bus.wr_color;
                sh_en_q[bus.wr_idx]    <= bus.wr_ena;
            end
        end
    end

`ifdef SPRITE_HFLIP_EN
    logic [NSPR-1:0] sh_hflip_q;
    logic [NSPR-1:0] ac_hflip_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh_hflip_q <= '0;
            ac_hflip_q <= '0;
        end else begin
            if (swap) begin
                ac_hflip_q <= sh_hflip_q;
            end
            if (bus.wr_en) begin
                sh_hflip_q[bus.wr_idx] <= bus.wr_hflip;
            end
        end
    end

    assign flip = ac_hflip_q;
`else
    assign flip = '0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            addr_q  <= addr_d;
        end
    end

    // The ROM samples bmp_addr at the end of ADDR, so the address is presented
    // combinationally during ADDR and held in addr_q afterwards.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        addr_d    = addr_q;
        lb_we     = 1'b0;
        next_line = (bus.vpos == VLAST) ? 11'd0 : (bus.vpos + 11'd1);
        row       = next_line - ac_y_q[idx_q];
        row_hit   = ac_en_q[idx_q] && (row < SPR_H_11);
        unique case (state_q)
            S_IDLE: begin
                if (bus.hpos == HA) begin
                    state_d = S_ADDR;
                    idx_d   = '0;
                end
            end
            S_ADDR: begin
                hit_d   = row_hit;
                state_d = S_DATA;
                if (row_hit) begin
                    addr_d = {ac_code_q[idx_q], row[ROW_W-1:0]};
                end
            end
            S_DATA: begin
                lb_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.bmp_addr = addr_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NSPR; i++) begin
                linebuf_q[i] <= '0;
            end
            lvalid_q <= '0;
        end else if (lb_we) begin
            lvalid_q[idx_q] <= hit_q;
            if (hit_q) begin
                linebuf_q[idx_q] <= bus.bmp_data;
            end
        end
    end

    // Lowest index wins: the first opaque sprite found supplies the colour.
    always_comb begin
        any_opaque   = 1'b0;
        multi_opaque = 1'b0;
        rgb_sel      = 3'b000;
        opaque       = '0;
        for (int i = 0; i < NSPR; i++) begin
            col[i]     = bus.hpos - ac_x_q[i];
            bit_idx[i] = flip[i] ? col[i][COL_W-1:0] : (COL_MAX - col[i][COL_W-1:0]);
            opaque[i]  = lvalid_q[i] && (col[i] < SPR_W_11) && linebuf_q[i][bit_idx[i]];
            if (opaque[i]) begin
                if (any_opaque) begin
                    multi_opaque = 1'b1;
                end else begin
                    rgb_sel = ac_color_q[i];
                end
                any_opaque = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pix_on_q    <= 1'b0;
            pix_rgb_q   <= 3'b000;
            collision_q <= 1'b0;
        end else begin
            pix_on_q  <= bus.display_on && any_opaque;
            pix_rgb_q <= (bus.display_on && any_opaque) ? rgb_sel : 3'b000;
            if (swap) begin
                collision_q <= 1'b0;
            end else if (bus.display_on && multi_opaque) begin
                collision_q <= 1'b1;
            end
        end
    end

    assign bus.pix_on    = pix_on_q;
    assign bus.pix_rgb   = pix_rgb_q;
    assign bus.collision = collision_q;
endmodule
